// File: rtl/reh_seq_pkg.sv
// -----------------------------------------------------------------------------
// reh_seq_pkg
// Shared definitions for the sequential 16x16 multiplier controller:
//   - FSM state encoding (IDLE / CALC / DONE)
//   - partial-product step indices (LL, LH, HL, HH)
//   - accumulator shift amounts for each step
// -----------------------------------------------------------------------------
package reh_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Step index: bit 1 selects the high half of a, bit 0 the high half of x.
    typedef logic [1:0] step_t;

    localparam step_t STEP_LL = 2'd0;   // a_lo * x_lo
    localparam step_t STEP_LH = 2'd1;   // a_lo * x_hi
    localparam step_t STEP_HL = 2'd2;   // a_hi * x_lo
    localparam step_t STEP_HH = 2'd3;   // a_hi * x_hi

    localparam logic [4:0] SHIFT_LL = 5'd0;
    localparam logic [4:0] SHIFT_LH = 5'd8;
    localparam logic [4:0] SHIFT_HL = 5'd8;
    localparam logic [4:0] SHIFT_HH = 5'd16;

endpackage

// File: rtl/reh_pp_select.sv
// -----------------------------------------------------------------------------
// reh_pp_select
// Combinational operand/shift selector for one partial-product step.
// Ports:
//   a_i     [15:0] registered multiplicand
//   x_i     [15:0] registered multiplier
//   step_i  [1:0]  step index (LL/LH/HL/HH)
//   mul_a_o [7:0]  8-bit half of a for this step
//   mul_x_o [7:0]  8-bit half of x for this step
//   shift_o [4:0]  left shift applied to the 16-bit partial product
// -----------------------------------------------------------------------------
module reh_pp_select
    import reh_seq_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] x_i,
    input  step_t       step_i,
    output logic [7:0]  mul_a_o,
    output logic [7:0]  mul_x_o,
    output logic [4:0]  shift_o
);

    always_comb begin
        mul_a_o = a_i[7:0];
        mul_x_o = x_i[7:0];
        shift_o = SHIFT_LL;
        case (step_i)
            STEP_LL: begin
                mul_a_o = a_i[7:0];
                mul_x_o = x_i[7:0];
                shift_o = SHIFT_LL;
            end
            STEP_LH: begin
                mul_a_o = a_i[7:0];
                mul_x_o = x_i[15:8];
                shift_o = SHIFT_LH;
            end
            STEP_HL: begin
                mul_a_o = a_i[15:8];
                mul_x_o = x_i[7:0];
                shift_o = SHIFT_HL;
            end
            default: begin
                mul_a_o = a_i[15:8];
                mul_x_o = x_i[15:8];
                shift_o = SHIFT_HH;
            end
        endcase
    end

endmodule

// File: rtl/reh_seq_mul16_ctrl.sv
// -----------------------------------------------------------------------------
// reh_seq_mul16_ctrl
// Builds a 16x16 product from an external 8x8 multiplier core, one partial
// product per clock, accumulating LL<<0, LH<<8, HL<<8, HH<<16 into 32 bits.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    operand handshake (in_ready only while idle)
//   a, x       [15:0]    multiplicand / multiplier
//   out_valid/out_ready  result handshake
//   product    [31:0]    accumulated product, held stable while out_valid
//   mul_en               core enable, high only while a step is running
//   mul_a, mul_x [7:0]   core operands (forced to 0 when the core is idle)
//   mul_p      [15:0]    core result, combinational from mul_a/mul_x
// Parameter SKIP_ZERO: 1 skips steps whose operand half is zero.
// -----------------------------------------------------------------------------
module reh_seq_mul16_ctrl
    import reh_seq_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product,
    output logic        mul_en,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_x,
    input  logic [15:0] mul_p
);

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] x_q, x_d;
    logic [31:0] acc_q, acc_d;
    logic [3:0]  mask_q, mask_d;
    step_t       step_q, step_d;

    logic [3:0]  mask_new;
    step_t       first_step;
    step_t       next_step;
    logic        next_valid;
    logic [7:0]  sel_a, sel_x;
    logic [4:0]  sel_shift;

    // Step mask for the incoming operands; bit index follows the step
    // encoding, so bit 1 of the index picks a's half and bit 0 picks x's.
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
        localparam bit A_HI = (gi >= 2);
        localparam bit X_HI = ((gi % 2) == 1);
        logic [7:0] a_half;
        logic [7:0] x_half;
        assign a_half = A_HI ? a[15:8] : a[7:0];
        assign x_half = X_HI ? x[15:8] : x[7:0];
        assign mask_new[gi] = SKIP_ZERO ? ((|a_half) && (|x_half)) : 1'b1;
    end

    // Lowest set bit of the new mask, and the next set bit above the
    // current step in the registered mask.
    always_comb begin
        first_step = STEP_LL;
        next_step  = step_q;
        next_valid = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (mask_new[i]) begin
                first_step = step_t'(i);
            end
            if (mask_q[i] && (i > int'(step_q))) begin
                next_step  = step_t'(i);
                next_valid = 1'b1;
            end
        end
    end

    reh_pp_select u_pp_select (
        .a_i     (a_q),
        .x_i     (x_q),
        .step_i  (step_q),
        .mul_a_o (sel_a),
        .mul_x_o (sel_x),
        .shift_o (sel_shift)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        x_d       = x_q;
        acc_d     = acc_q;
        mask_d    = mask_q;
        step_d    = step_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d    = a;
                    x_d    = x;
                    acc_d  = 32'd0;
                    mask_d = mask_new;
                    step_d = first_step;
                    // An all-zero mask means the product is known to be 0.
                    state_d = (mask_new != 4'd0) ? ST_CALC : ST_DONE;
                end
            end
            ST_CALC: begin
                mul_en = 1'b1;
                // Wraps modulo 2^32 if an approximate core overshoots.
                acc_d  = acc_q + ({16'd0, mul_p} << sel_shift);
                if (next_valid) begin
                    step_d = next_step;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Core operands held at zero outside CALC so the core does not toggle.
    assign mul_a   = mul_en ? sel_a : 8'd0;
    assign mul_x   = mul_en ? sel_x : 8'd0;
    assign product = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= 16'd0;
            x_q     <= 16'd0;
            acc_q   <= 32'd0;
            mask_q  <= 4'd0;
            step_q  <= STEP_LL;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            mask_q  <= mask_d;
            step_q  <= step_d;
        end
    end

endmodule

// File: tb/tb_reh_seq_mul16_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reh_seq_mul16_ctrl
// Two controllers (SKIP_ZERO=0 and SKIP_ZERO=1) share the operand stream,
// each with its own behavioural 8x8 core (exact, or a constant-1 stub).
// Expected products, latencies and step operands come from a reference
// model computed from the decomposition rules.
// -----------------------------------------------------------------------------
module tb_reh_seq_mul16_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a_i;
    logic [15:0] x_i;
    logic        stub;

    logic        in_ready  [2];
    logic        out_valid [2];
    logic        mul_en    [2];
    logic [31:0] product   [2];
    logic [7:0]  mul_a     [2];
    logic [7:0]  mul_x     [2];
    logic [15:0] mul_p     [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural cores
    assign mul_p[0] = stub ? 16'h0001 : ({8'd0, mul_a[0]} * {8'd0, mul_x[0]});
    assign mul_p[1] = stub ? 16'h0001 : ({8'd0, mul_a[1]} * {8'd0, mul_x[1]});

    reh_seq_mul16_ctrl #(.SKIP_ZERO(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .a(a_i), .x(x_i), .out_valid(out_valid[0]), .out_ready(out_ready),
        .product(product[0]), .mul_en(mul_en[0]), .mul_a(mul_a[0]),
        .mul_x(mul_x[0]), .mul_p(mul_p[0])
    );

    reh_seq_mul16_ctrl #(.SKIP_ZERO(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .a(a_i), .x(x_i), .out_valid(out_valid[1]), .out_ready(out_ready),
        .product(product[1]), .mul_en(mul_en[1]), .mul_a(mul_a[1]),
        .mul_x(mul_x[1]), .mul_p(mul_p[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Step tables in LL, LH, HL, HH order
    function automatic logic [7:0] step_a(input logic [15:0] v, input int s);
        return (s >= 2) ? v[15:8] : v[7:0];
    endfunction

    function automatic logic [7:0] step_x(input logic [15:0] v, input int s);
        return (s == 1 || s == 3) ? v[15:8] : v[7:0];
    endfunction

    function automatic int step_shift(input int s);
        case (s)
            0:       return 0;
            1, 2:    return 8;
            default: return 16;
        endcase
    endfunction

    function automatic logic [3:0] model_mask(input logic [15:0] a, input logic [15:0] x, input bit skip);
        logic [3:0] m;
        m = 4'hF;
        if (skip) begin
            for (int s = 0; s < 4; s++) begin
                m[s] = (step_a(a, s) != 8'd0) && (step_x(x, s) != 8'd0);
            end
        end
        return m;
    endfunction

    function automatic logic [31:0] model_prod(input logic [15:0] a, input logic [15:0] x,
                                               input logic [3:0] m, input bit is_stub);
        logic [31:0] sum;
        logic [31:0] pp;
        sum = 32'd0;
        for (int s = 0; s < 4; s++) begin
            if (m[s]) begin
                pp  = is_stub ? 32'd1 : (32'(step_a(a, s)) * 32'(step_x(x, s)));
                sum = sum + (pp << step_shift(s));
            end
        end
        return sum;
    endfunction

    // Runs one operand pair through both controllers and checks everything.
    task automatic run_txn(input logic [15:0] a, input logic [15:0] x, input int hold,
                           output logic [31:0] p0, output logic [31:0] p1);
        logic [3:0]  m       [2];
        logic [31:0] expp    [2];
        int          lat     [2];
        int          en_cnt  [2];
        int          seen    [2];
        int          cyc;
        int          s;
        for (int d = 0; d < 2; d++) begin
            m[d]      = model_mask(a, x, d == 1);
            expp[d]   = model_prod(a, x, m[d], stub);
            lat[d]    = 0;
            en_cnt[d] = 0;
            seen[d]   = 0;
        end
        @(negedge clk);
        check_eq("in_ready_idle0", 32'(in_ready[0]), 32'd1);
        check_eq("in_ready_idle1", 32'(in_ready[1]), 32'd1);
        in_valid = 1'b1;
        a_i = a;
        x_i = x;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_i = 16'($urandom);
        x_i = 16'($urandom);
        cyc = 0;
        while ((lat[0] == 0 || lat[1] == 0) && cyc < 20) begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (lat[d] == 0) begin
                    if (out_valid[d]) begin
                        lat[d] = cyc;
                    end else if (mul_en[d]) begin
                        // find the seen[d]-th set step of the mask
                        s = -1;
                        for (int k = 0, n = 0; k < 4; k++) begin
                            if (m[d][k]) begin
                                if (n == seen[d] && s < 0) s = k;
                                n++;
                            end
                        end
                        seen[d]++;
                        en_cnt[d]++;
                        if (s >= 0) begin
                            check_eq($sformatf("mul_a%0d", d), 32'(mul_a[d]), 32'(step_a(a, s)));
                            check_eq($sformatf("mul_x%0d", d), 32'(mul_x[d]), 32'(step_x(x, s)));
                        end else begin
                            check_eq($sformatf("extra_step%0d", d), 32'(en_cnt[d]), 32'($countones(m[d])));
                        end
                    end
                end
                if (!mul_en[d]) begin
                    check_eq($sformatf("idle_ops%0d", d), {16'd0, mul_a[d], mul_x[d]}, 32'd0);
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (lat[d] == 0) begin
                check_eq($sformatf("timeout%0d", d), 32'd0, 32'd1);
            end
            // out_valid first seen in the cycle after the last step's edge,
            // or the cycle right after accept when nothing needs computing.
            check_eq($sformatf("latency%0d", d), 32'(lat[d]),
                     ($countones(m[d]) == 0) ? 32'd1 : 32'($countones(m[d]) + 1));
            check_eq($sformatf("en_cycles%0d", d), 32'(en_cnt[d]), 32'($countones(m[d])));
            check_eq($sformatf("product%0d", d), product[d], expp[d]);
            check_eq($sformatf("busy_ready%0d", d), 32'(in_ready[d]), 32'd0);
        end
        if (!stub) begin
            check_eq("product_exact", product[0], 32'(a) * 32'(x));
        end
        p0 = product[0];
        p1 = product[1];
        for (int h = 0; h < hold; h++) begin
            in_valid = (h == 0);
            a_i = 16'($urandom);
            x_i = 16'($urandom);
            @(negedge clk);
            in_valid = 1'b0;
            for (int d = 0; d < 2; d++) begin
                check_eq($sformatf("hold_prod%0d", d), product[d], expp[d]);
                check_eq($sformatf("hold_valid%0d", d), 32'(out_valid[d]), 32'd1);
                check_eq($sformatf("hold_ready%0d", d), 32'(in_ready[d]), 32'd0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("post_valid%0d", d), 32'(out_valid[d]), 32'd0);
            check_eq($sformatf("post_ready%0d", d), 32'(in_ready[d]), 32'd1);
        end
        $display("txn a=0x%04h x=0x%04h stub=%0d p0=0x%08h p1=0x%08h lat=%0d/%0d",
                 a, x, stub, p0, p1, lat[0], lat[1]);
    endtask

    initial begin
        logic [31:0] p0, p1;
        logic [15:0] ra, rx;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_i       = 16'd0;
        x_i       = 16'd0;
        stub      = 1'b0;
        #3;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rst_ready%0d", d), 32'(in_ready[d]), 32'd1);
            check_eq($sformatf("rst_valid%0d", d), 32'(out_valid[d]), 32'd0);
            check_eq($sformatf("rst_prod%0d", d), product[d], 32'd0);
            check_eq($sformatf("rst_core%0d", d), {15'd0, mul_en[d], mul_a[d], mul_x[d]}, 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_txn(16'h1234, 16'h5678, 0, p0, p1);
        check_eq("dir_1234x5678", p0, 32'h06260060);
        run_txn(16'hFFFF, 16'hFFFF, 0, p0, p1);
        check_eq("dir_ffffxffff", p0, 32'hFFFE0001);
        stub = 1'b1;
        run_txn(16'h0101, 16'h0101, 0, p0, p1);
        check_eq("dir_stub_shift", p0, 32'h00010201);
        stub = 1'b0;
        run_txn(16'h00FF, 16'h0100, 0, p0, p1);
        check_eq("dir_lh_only", p1, 32'h0000FF00);
        run_txn(16'h0000, 16'hBEEF, 0, p0, p1);
        check_eq("dir_zero_mask", p1, 32'h00000000);
        run_txn(16'hA5C3, 16'h3C5A, 3, p0, p1);

        // Reset in the middle of a computation
        @(negedge clk);
        in_valid = 1'b1;
        a_i = 16'hFFFF;
        x_i = 16'hFFFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check_eq("partial_acc", product[0], 32'h00FEFF01);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("arst_ready%0d", d), 32'(in_ready[d]), 32'd1);
            check_eq($sformatf("arst_valid%0d", d), 32'(out_valid[d]), 32'd0);
            check_eq($sformatf("arst_prod%0d", d), product[d], 32'd0);
            check_eq($sformatf("arst_core%0d", d), {15'd0, mul_en[d], mul_a[d], mul_x[d]}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(16'h0003, 16'h0005, 0, p0, p1);
        check_eq("post_rst_prod", p1, 32'h0000000F);

        // Randomized traffic, with halves zeroed often to exercise skipping
        for (int t = 0; t < 24; t++) begin
            ra = 16'($urandom);
            rx = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra[7:0]  = 8'd0;
            if ($urandom_range(0, 3) == 0) ra[15:8] = 8'd0;
            if ($urandom_range(0, 3) == 0) rx[7:0]  = 8'd0;
            if ($urandom_range(0, 3) == 0) rx[15:8] = 8'd0;
            stub = ($urandom_range(0, 4) == 0);
            run_txn(ra, rx, int'($urandom_range(0, 2)), p0, p1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
